fifo_rd_drain: RTL
==================

# fifo_rd_drain

Read-side drain stage sitting directly downstream of the async FIFO's read port, in the read clock domain. Issues read enables only when the FIFO is non-empty and space is guaranteed. Absorbs the FIFO's one-cycle read latency in a 2-entry skid buffer and presents the data as a valid/ready stream at full throughput with no bubbles. Also keeps a sticky copy of the FIFO read error and a delivered-word count.

## Interface
- WIDTH, default `WIDTH: data width; must match the FIFO data width.
- CNT_W, default 16: width of the delivered-word counter.

- rclk_i  in  1  read clock; the only clock.
- rst_i  in  1  asynchronous reset, active-low.
- empty_i  in  1  FIFO empty flag.
- rdata_i  in  WIDTH  FIFO read data; valid the cycle after the matching rd_en_o.
- error_i  in  1  FIFO read error flag.
- rd_en_o  out  1  FIFO read enable.
- m_valid_o  out  1  output word valid.
- m_data_o  out  WIDTH  output word.
- m_ready_i  in  1  downstream ready.
- flush_i  in  1  synchronous discard of buffered and in-flight data.
- err_clr_i  in  1  clears err_sticky_o.
- err_sticky_o  out  1  set by any error_i pulse.
- rd_count_o  out  CNT_W  count of accepted output handshakes.

## Operation
- Reset values: rd_en_o=0, m_valid_o=0, m_data_o=0, err_sticky_o=0, rd_count_o=0. Buffer occupancy is EMPTY and inflight=0.
- Occupancy states:
  - EMPTY, ONE, TWO.
  - Transitions on push (captured read data) and pop (m_valid_o && m_ready_i).
  - push only: +1. pop only: -1. Both: unchanged.
- inflight: register equal to the previous cycle's rd_en_o && !flush_i.
- push = inflight (the word on rdata_i is written to the tail).
- rd_en_o = !empty_i && !flush_i && (occ + inflight - pop) < 2. This path is combinational from m_ready_i, empty_i and flush_i.
- rd_en_o is never high while empty_i=1. The block must never cause a FIFO underflow.
- Head is m_data_o. With occupancy TWO, a pop moves the tail to the head.
- With occupancy ONE, push and pop in the same cycle load the new word directly into the head.
- Ordering is strict FIFO. No word is lost or duplicated under any m_ready_i pattern.
- flush_i=1:
  - Next cycle occupancy is EMPTY and m_valid_o=0.
  - A word arriving on rdata_i that cycle or the next (from a read issued before the flush) is discarded.
  - rd_en_o is held 0.
  - rd_count_o is unchanged.
- err_sticky_o:
  - Set on error_i=1.
  - Cleared on err_clr_i=1 when error_i=0.
  - If both are high in the same cycle, set wins.
- rd_count_o increments by 1 per handshake and wraps modulo 2^CNT_W.
- m_data_o is stable while m_valid_o=1 && m_ready_i=0.

## Timing
- Latency: rd_en_o in cycle N, rdata_i valid in N+1, m_valid_o high in N+2.
- Throughput: 1 word/cycle sustained when FIFO non-empty and m_ready_i=1.
- Backpressure: with m_ready_i=0, at most 2 reads are outstanding (buffer plus inflight), then rd_en_o=0.
- Reset mid-operation: buffered and in-flight data are dropped and all outputs return to reset values immediately. The FIFO's own reset is handled separately.

## Structure
- Package fifo_rd_pkg holds:
  - typedef enum occ_e {OCC_EMPTY, OCC_ONE, OCC_TWO}.
  - localparam SKID_DEPTH=2.
- Sub-module fifo_rd_skid: 2-entry head/tail buffer with occupancy FSM, push/pop/flush inputs, and head/valid outputs.
- The top level holds:
  - rd_en_o logic.
  - inflight and discard tracking.
  - error sticky.
  - counter.

## Test plan
- Reset: hold rst_i=0 with FIFO non-empty. Required: rd_en_o=0, m_valid_o=0, rd_count_o=0, err_sticky_o=0 throughout.
- Streaming: FIFO holds 0xA1..0xA4, m_ready_i=1. Required: rd_en_o high in cycles 0-3, m_data_o = A1..A4 in cycles 2-5, rd_count_o=4.
- Backpressure:
  - FIFO holds 5 words, m_ready_i=0. Required: exactly 2 rd_en_o pulses and m_data_o=A1 held stable.
  - Release with m_ready_i toggling 1,0,1... Required: A1..A5 in order, no duplicates.
- Empty boundary: empty_i rises while a read is in flight. Required: rd_en_o=0 from that cycle, the in-flight word is still delivered, and no error_i occurs.
- Flush: assert flush_i in the cycle after rd_en_o with occupancy ONE. Required: m_valid_o=0 next cycle, the in-flight word never appears, rd_count_o unchanged.
- Error sticky:
  - error_i and err_clr_i pulse in the same cycle. Required: err_sticky_o=1.
  - err_clr_i alone later. Required: err_sticky_o=0.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-side drain stage.
package fifo_rd_pkg;

  // Skid buffer fill level.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  // Entries in the skid buffer; this is also the cap on buffered plus
  // in-flight reads.
  localparam int SKID_DEPTH = 2;

  // Number of words held for a given occupancy state.
  function automatic logic [1:0] occ_count(input occ_e occ);
    logic [1:0] n;
    case (occ)
      OCC_ONE: n = 2'd1;
      OCC_TWO: n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry head/tail skid buffer. The head register drives the output
// directly, so it holds steady while the consumer stalls. The tail only
// fills when a word arrives while the head is still waiting to be taken.
//
// state     | meaning
// OCC_EMPTY | no word buffered, valid_o low
// OCC_ONE   | head holds the oldest word, tail unused
// OCC_TWO   | head holds the oldest word, tail holds the next one
import fifo_rd_pkg::*;

module fifo_rd_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] head_o,
  output logic             valid_o,
  output occ_e             occ_o
);

  occ_e             occ_q, occ_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;

  // State and data registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occ_q  <= OCC_EMPTY;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Occupancy transitions and data movement on push/pop/flush.
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    if (flush_i) begin
      occ_d = OCC_EMPTY;
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (push_i) begin
            head_d = din_i;
            occ_d  = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (push_i && pop_i) begin
            // Head leaves and the arriving word replaces it in one step.
            head_d = din_i;
          end else if (push_i) begin
            tail_d = din_i;
            occ_d  = OCC_TWO;
          end else if (pop_i) begin
            occ_d = OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          // A push without a pop cannot happen here: the read issue logic
          // never lets buffered plus in-flight words exceed two.
          if (pop_i) begin
            head_d = tail_q;
            if (push_i) begin
              tail_d = din_i;
            end else begin
              occ_d = OCC_ONE;
            end
          end
        end
        default: begin
          occ_d = OCC_EMPTY;
        end
      endcase
    end
  end

  assign head_o  = head_q;
  assign valid_o = (occ_q != OCC_EMPTY);
  assign occ_o   = occ_q;

endmodule

// File: rtl/fifo_rd_drain.sv
// Read-side drain stage for the async FIFO, read clock domain. Issues FIFO
// reads only when the word is guaranteed a slot, absorbs the one-cycle read
// latency in the skid buffer, and presents a valid/ready stream. Also keeps
// a sticky read-error flag and a delivered-word counter.
import fifo_rd_pkg::*;

module fifo_rd_drain #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             rclk_i,
  input  logic             rst_i,
  input  logic             empty_i,
  input  logic [WIDTH-1:0] rdata_i,
  input  logic             error_i,
  output logic             rd_en_o,
  output logic             m_valid_o,
  output logic [WIDTH-1:0] m_data_o,
  input  logic             m_ready_i,
  input  logic             flush_i,
  input  logic             err_clr_i,
  output logic             err_sticky_o,
  output logic [CNT_W-1:0] rd_count_o
);

  logic             inflight_q, inflight_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             pop;
  logic             push;
  logic             handshake;
  occ_e             occ;
  logic [2:0]       level;

  // Handshake as seen by the consumer.
  assign pop       = m_valid_o && m_ready_i;
  // A flush drops the buffer outright, so a coincident handshake is not
  // counted as a delivery.
  assign handshake = pop && !flush_i;
  // The word returned for last cycle's read; discarded if a flush lands on
  // its arrival cycle.
  assign push      = inflight_q && !flush_i;

  fifo_rd_skid #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk_i   (rclk_i),
    .rst_ni  (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush_i),
    .din_i   (rdata_i),
    .head_o  (m_data_o),
    .valid_o (m_valid_o),
    .occ_o   (occ)
  );

  // Words that will still need a slot after this cycle's pop. A pop always
  // implies at least one buffered word, so this never goes negative.
  assign level = 3'(occ_count(occ)) + 3'(inflight_q) - 3'(pop);

  // Read issue; gated by reset so a non-empty FIFO cannot be read while the
  // stage is held in reset.
  always_comb begin
    rd_en_o = 1'b0;
    if (rst_i && !empty_i && !flush_i && (level < 3'(SKID_DEPTH))) begin
      rd_en_o = 1'b1;
    end
  end

  // Next-state for in-flight tracking, error sticky and delivery counter.
  always_comb begin
    inflight_d = rd_en_o && !flush_i;
    err_d      = err_q;
    if (error_i) begin
      err_d = 1'b1;
    end else if (err_clr_i) begin
      err_d = 1'b0;
    end
    cnt_d = cnt_q;
    if (handshake) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Control registers.
  always_ff @(posedge rclk_i or negedge rst_i) begin
    if (!rst_i) begin
      inflight_q <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      inflight_q <= inflight_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign err_sticky_o = err_q;
  assign rd_count_o   = cnt_q;

endmodule
